// File: rtl/ras_pkg.sv
// ras_pkg: shared sizes, checkpoint record and FSM states for the RAS controller
package ras_pkg;
  localparam int DEPTH = 32;
  localparam int CKPT = 4;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CKPT);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [AW-1:0] tos;
    logic [CW-1:0] count;
    logic [31:0]   top_data;
  } ras_ckpt_t;
  typedef enum logic {RUN, RECOVER} ras_state_e;
endpackage

// File: rtl/ras_ckpt_fifo.sv
// ras_ckpt_fifo: circular checkpoint buffer with allocate, head-free, flush-to-tag
// and a late top_data patch for slots whose value is only readable a cycle later.
module ras_ckpt_fifo
  import ras_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alloc_i,
  input  ras_ckpt_t     alloc_data_i,
  input  logic          free_i,
  input  logic          flush_i,
  input  logic [TW-1:0] flush_tag_i,
  input  logic          fix_i,
  input  logic [TW-1:0] fix_tag_i,
  input  logic [31:0]   fix_data_i,
  input  logic [TW-1:0] rd_tag_i,
  output ras_ckpt_t     rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          tag_ok_o,
  output logic [TW-1:0] head_o,
  output logic [TW-1:0] tail_o
);
  localparam logic [TW:0] FULL = CKPT;
  ras_ckpt_t mem_q [CKPT];
  logic [TW-1:0] head_q, tail_q;
  logic [TW:0] cnt_q;
  assign full_o = cnt_q == FULL;
  assign empty_o = cnt_q == '0;
  assign tag_ok_o = {1'b0, rd_tag_i - head_q} < cnt_q;
  assign rd_data_o = mem_q[rd_tag_i];
  assign head_o = head_q;
  assign tail_o = tail_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      tail_q <= flush_tag_i;
      cnt_q <= {1'b0, flush_tag_i - head_q};
    end else begin
      head_q <= head_q + TW'(free_i);
      tail_q <= tail_q + TW'(alloc_i);
      cnt_q <= cnt_q + (TW+1)'(alloc_i) - (TW+1)'(free_i);
    end
    if (alloc_i) mem_q[tail_q] <= alloc_data_i;
    if (fix_i) mem_q[fix_tag_i].top_data <= fix_data_i;
  end
endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: speculative return-address-stack controller with per-branch checkpoints.
// Optional RAS_CTRL_STATS_EN adds saturating event counters and a push/pop/restore trace.
module ras_ctrl
  import ras_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          FETCH_VALID_IN,
  input  logic          FETCH_CALL_IN,
  input  logic          FETCH_RET_IN,
  input  logic [31:0]   FETCH_LINK_IN,
  output logic          FETCH_STALL_OUT,
  output logic [TW-1:0] FETCH_TAG_OUT,
  output logic          PRED_VALID_OUT,
  output logic [31:0]   PRED_ADDR_OUT,
  input  logic          RESOLVE_VALID_IN,
  input  logic          RESOLVE_MISPRED_IN,
  input  logic [TW-1:0] RESOLVE_TAG_IN,
  output logic          STK_WE_OUT,
  output logic [AW-1:0] STK_WADDR_OUT,
  output logic [31:0]   STK_WDATA_OUT,
  output logic [AW-1:0] STK_RADDR_OUT,
  input  logic [31:0]   STK_RDATA_IN
);
  ras_state_e state_q;
  logic [AW-1:0] tos_q, tos_d;
  logic [CW-1:0] count_q, count_d;
  logic fix_q;
  logic [TW-1:0] fix_tag_q, head, tail;
  logic [31:0] rec_data_q;
  logic full, empty, tag_ok, accept, push, pop, mispred, free, rec_wr;
  ras_ckpt_t ck_rd, ck_new;
  assign rec_wr = RESET_N & (state_q == RECOVER);
  assign mispred = RESET_N & RESOLVE_VALID_IN & RESOLVE_MISPRED_IN & tag_ok;
  assign free = RESET_N & RESOLVE_VALID_IN & !RESOLVE_MISPRED_IN & !empty & (RESOLVE_TAG_IN == head);
  assign accept = RESET_N & FETCH_VALID_IN & (state_q == RUN) & !full & !RESOLVE_MISPRED_IN;
  assign push = accept & FETCH_CALL_IN;
  assign pop = accept & !FETCH_CALL_IN & FETCH_RET_IN & (count_q != '0);
  assign tos_d = push ? tos_q + AW'(1) : pop ? tos_q - AW'(1) : tos_q;
  assign count_d = push ? count_q + {{AW{1'b0}}, count_q != CW'(DEPTH)} : pop ? count_q - CW'(1) : count_q;
  // a pop's new top is not on the read port yet; its slot is patched next cycle via fix_q
  assign ck_new = '{tos: tos_d, count: count_d, top_data: push ? FETCH_LINK_IN : STK_RDATA_IN};
  assign FETCH_STALL_OUT = RESET_N & FETCH_VALID_IN & !accept;
  assign FETCH_TAG_OUT = accept ? tail : '0;
  assign PRED_VALID_OUT = pop;
  assign PRED_ADDR_OUT = pop ? STK_RDATA_IN : '0;
  assign STK_WE_OUT = push | rec_wr;
  assign STK_WADDR_OUT = rec_wr ? tos_q : push ? tos_d : '0;
  assign STK_WDATA_OUT = rec_wr ? rec_data_q : push ? FETCH_LINK_IN : '0;
  assign STK_RADDR_OUT = tos_q;
  ras_ckpt_fifo u_fifo (
    .clk_i(CLK),
    .rst_ni(RESET_N),
    .alloc_i(accept),
    .alloc_data_i(ck_new),
    .free_i(free),
    .flush_i(mispred),
    .flush_tag_i(RESOLVE_TAG_IN),
    .fix_i(fix_q),
    .fix_tag_i(fix_tag_q),
    .fix_data_i(STK_RDATA_IN),
    .rd_tag_i(RESOLVE_TAG_IN),
    .rd_data_o(ck_rd),
    .full_o(full),
    .empty_o(empty),
    .tag_ok_o(tag_ok),
    .head_o(head),
    .tail_o(tail)
  );
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= RUN;
      tos_q <= '0;
      count_q <= '0;
      fix_q <= 1'b0;
      fix_tag_q <= '0;
      rec_data_q <= '0;
    end else if (mispred) begin
      state_q <= RECOVER;
      tos_q <= ck_rd.tos;
      count_q <= ck_rd.count;
      rec_data_q <= (fix_q && fix_tag_q == RESOLVE_TAG_IN) ? STK_RDATA_IN : ck_rd.top_data;
      fix_q <= 1'b0;
    end else begin
      state_q <= RUN;
      tos_q <= tos_d;
      count_q <= count_d;
      fix_q <= pop;
      fix_tag_q <= tail;
    end
  end
`ifdef RAS_CTRL_STATS_EN
  logic [15:0] ovf_q, unf_q, rcv_q;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ovf_q <= '0;
      unf_q <= '0;
      rcv_q <= '0;
    end else begin
      if (push && count_q == CW'(DEPTH) && ovf_q != '1) ovf_q <= ovf_q + 16'd1;
      if (accept && !FETCH_CALL_IN && FETCH_RET_IN && count_q == '0 && unf_q != '1) unf_q <= unf_q + 16'd1;
      if (mispred && rcv_q != '1) rcv_q <= rcv_q + 16'd1;
      if (push) $display("[ras] push %08h @%0d", FETCH_LINK_IN, tos_d);
      if (pop) $display("[ras] pop  %08h @%0d", STK_RDATA_IN, tos_q);
      if (mispred) $display("[ras] restore tag %0d tos %0d count %0d", RESOLVE_TAG_IN, ck_rd.tos, ck_rd.count);
    end
  end
`endif
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed plan scenarios plus random traffic checked against a
// stack/checkpoint-queue reference model; bench owns the RAS storage array.
module tb_ras_ctrl;
  localparam int DEPTH = 32;
  localparam int CKPT = 4;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic FETCH_VALID_IN = 1'b0, FETCH_CALL_IN = 1'b0, FETCH_RET_IN = 1'b0;
  logic [31:0] FETCH_LINK_IN = '0;
  logic RESOLVE_VALID_IN = 1'b0, RESOLVE_MISPRED_IN = 1'b0;
  logic [1:0] RESOLVE_TAG_IN = '0;
  logic FETCH_STALL_OUT, PRED_VALID_OUT, STK_WE_OUT;
  logic [1:0] FETCH_TAG_OUT;
  logic [31:0] PRED_ADDR_OUT, STK_WDATA_OUT, STK_RDATA_IN;
  logic [4:0] STK_WADDR_OUT, STK_RADDR_OUT;
  logic [31:0] stor [DEPTH];
  typedef struct {
    logic [1:0]  tag;
    int          tos;
    int          cnt;
    logic [31:0] data;
  } ck_t;
  ck_t q[$];
  logic [31:0] m_mem [DEPTH];
  int m_tos, m_cnt;
  logic [1:0] m_tail;
  bit m_rec;
  int n_tests = 0, n_fail = 0;
  ras_ctrl dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .FETCH_VALID_IN(FETCH_VALID_IN),
    .FETCH_CALL_IN(FETCH_CALL_IN),
    .FETCH_RET_IN(FETCH_RET_IN),
    .FETCH_LINK_IN(FETCH_LINK_IN),
    .FETCH_STALL_OUT(FETCH_STALL_OUT),
    .FETCH_TAG_OUT(FETCH_TAG_OUT),
    .PRED_VALID_OUT(PRED_VALID_OUT),
    .PRED_ADDR_OUT(PRED_ADDR_OUT),
    .RESOLVE_VALID_IN(RESOLVE_VALID_IN),
    .RESOLVE_MISPRED_IN(RESOLVE_MISPRED_IN),
    .RESOLVE_TAG_IN(RESOLVE_TAG_IN),
    .STK_WE_OUT(STK_WE_OUT),
    .STK_WADDR_OUT(STK_WADDR_OUT),
    .STK_WDATA_OUT(STK_WDATA_OUT),
    .STK_RADDR_OUT(STK_RADDR_OUT),
    .STK_RDATA_IN(STK_RDATA_IN)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (STK_WE_OUT) stor[STK_WADDR_OUT] <= STK_WDATA_OUT;
  assign STK_RDATA_IN = stor[STK_RADDR_OUT];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic step(input bit v, input bit c, input bit r, input logic [31:0] link,
                      input bit rv, input bit rm, input logic [1:0] rt);
    bit acc;
    int idx;
    @(negedge CLK);
    FETCH_VALID_IN = v;
    FETCH_CALL_IN = c;
    FETCH_RET_IN = r;
    FETCH_LINK_IN = link;
    RESOLVE_VALID_IN = rv;
    RESOLVE_MISPRED_IN = rm;
    RESOLVE_TAG_IN = rt;
    #1;
    acc = v && !m_rec && q.size() < CKPT && !rm;
    chk("stall", FETCH_STALL_OUT, v && !acc);
    chk("raddr", STK_RADDR_OUT, m_tos);
    chk("we", STK_WE_OUT, m_rec || (acc && c));
    if (m_rec) begin
      chk("rec_waddr", STK_WADDR_OUT, m_tos);
      chk("rec_wdata", STK_WDATA_OUT, m_mem[m_tos]);
    end
    if (acc) chk("tag", FETCH_TAG_OUT, m_tail);
    if (acc && c) begin
      chk("push_waddr", STK_WADDR_OUT, (m_tos + 1) % DEPTH);
      chk("push_wdata", STK_WDATA_OUT, link);
    end
    if (acc && r && !c) begin
      chk("pred_v", PRED_VALID_OUT, m_cnt > 0);
      if (m_cnt > 0) chk("pred_addr", PRED_ADDR_OUT, m_mem[m_tos]);
    end else chk("pred_idle", PRED_VALID_OUT, 1'b0);
    m_rec = 0;
    if (rv && rm) begin
      idx = -1;
      foreach (q[i]) if (q[i].tag == rt) idx = i;
      if (idx >= 0) begin
        m_tos = q[idx].tos;
        m_cnt = q[idx].cnt;
        m_mem[m_tos] = q[idx].data;
        m_tail = rt;
        while (q.size() > idx) q.delete(q.size() - 1);
        m_rec = 1;
      end
    end else if (rv && q.size() > 0 && q[0].tag == rt) q.delete(0);
    if (acc) begin
      if (c) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = link;
        if (m_cnt < DEPTH) m_cnt++;
      end else if (r && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
      q.push_back('{m_tail, m_tos, m_cnt, m_mem[m_tos]});
      m_tail++;
    end
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    FETCH_VALID_IN = 1'b1;
    FETCH_CALL_IN = 1'b1;
    FETCH_RET_IN = 1'b0;
    FETCH_LINK_IN = $urandom;
    RESOLVE_VALID_IN = 1'b0;
    RESOLVE_MISPRED_IN = 1'b0;
    #1;
    chk("rst_we", STK_WE_OUT, 1'b0);
    chk("rst_stall", FETCH_STALL_OUT, 1'b0);
    chk("rst_pred", {PRED_VALID_OUT, PRED_ADDR_OUT[30:0]}, 32'h0);
    chk("rst_wdata", STK_WDATA_OUT, 32'h0);
    chk("rst_waddr", {FETCH_TAG_OUT, STK_WADDR_OUT}, 32'h0);
    @(negedge CLK);
    #1;
    chk("rst_raddr", STK_RADDR_OUT, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      stor[i] = '0;
      m_mem[i] = '0;
    end
    m_tos = 0;
    m_cnt = 0;
    m_tail = '0;
    m_rec = 0;
    q.delete();
    RESET_N = 1'b1;
    FETCH_VALID_IN = 1'b0;
  endtask
  task automatic op(input bit c, input bit r, input logic [31:0] link);
    step(1'b1, c, r, link, q.size() > 0, 1'b0, q.size() > 0 ? q[0].tag : 2'd0);
  endtask
  initial begin
    int rnd, k;
    do_reset();
    op(0, 1, 0);
    op(1, 0, 32'h100);
    op(1, 0, 32'h200);
    op(0, 1, 0);
    op(0, 1, 0);
    op(0, 1, 0);
    do_reset();
    for (int i = 1; i <= 33; i++) op(1, 0, i);
    for (int i = 0; i < 33; i++) op(0, 1, 0);
    do_reset();
    step(1, 1, 0, 32'h400, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h500, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 2'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 2'd0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'hABC, 1, 1, 2'd2);
    step(1, 1, 0, 32'hDEF, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 32'h600, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, q[0].tag);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom_range(0, 15);
      if (q.size() > 0 && !m_rec && rnd < 2) begin
        k = $urandom_range(0, q.size() - 1);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom,
             1'b1, 1'b1, q[k].tag);
      end else if (q.size() > 0 && rnd < 10) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom,
             1'b1, 1'b0, rnd == 9 ? q[0].tag + 2'd1 : q[0].tag);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom,
             1'b0, 1'b0, 2'd0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
